mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_arith.sv | 48 ++++
 rtl/mdu.sv | 97 +++++++++
 tb/tb_mdu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU constants: operation encodings, default latencies and FSM state type.
package mdu_pkg;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned MulLatDefault = 5;
  localparam int unsigned DivLatDefault = 10;

  typedef enum logic {
    StIdle,
    StBusy
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {hi, lo} result of a multiply or divide.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  mdu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, sq, sr, uq, ur;

  assign prod_u = {32'b0, a_i} * {32'b0, b_i};
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

  // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
  assign abs_a = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign abs_b = b_i[31] ? (~b_i + 32'd1) : b_i;
  // Divide-by-zero results are discarded by the caller; avoid X propagation.
  assign div_b = (b_i == 32'd0) ? 32'd1 : b_i;

  always_comb begin
    sq = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
    sr = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
    if (a_i[31] ^ b_i[31]) begin
      sq = ~sq + 32'd1;
    end
    if (a_i[31]) begin
      sr = ~sr + 32'd1;
    end
  end

  assign uq = a_i / div_b;
  assign ur = a_i % div_b;

  always_comb begin
    res_o = '0;
    case (mdu_op_i)
      OpMult:  res_o = prod_s;
      OpMultu: res_o = prod_u;
      OpDiv:   res_o = {sr, sq};
      OpDivu:  res_o = {ur, uq};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: IDLE/BUSY controller, latency counter and HI/LO state.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned DIV_LAT = DivLatDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, th_q, th_d, tl_q, tl_d;
  logic [63:0] res;

  mdu_arith u_arith (
    .mdu_op_i (MDUOp),
    .a_i      (A),
    .b_i      (B),
    .res_o    (res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    th_d    = th_q;
    tl_d    = tl_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          case (MDUOp)
            OpMult, OpMultu: begin
              th_d    = res[63:32];
              tl_d    = res[31:0];
              cnt_d   = 5'(MUL_LAT);
              state_d = StBusy;
            end
            OpDiv, OpDivu: begin
              // Divide by zero commits the current HI/LO, leaving them unchanged.
              th_d    = (B == 32'd0) ? hi_q : res[63:32];
              tl_d    = (B == 32'd0) ? lo_q : res[31:0];
              cnt_d   = 5'(DIV_LAT);
              state_d = StBusy;
            end
            OpMthi:  hi_d = A;
            OpMtlo:  lo_d = A;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q == 5'd1) begin
          hi_d    = th_q;
          lo_d    = tl_q;
          cnt_d   = 5'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      th_q    <= 32'd0;
      tl_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      th_q    <= th_d;
      tl_q    <= tl_d;
    end
  end

  assign Busy = (state_q == StBusy);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors plus randomized ops against a reference model.
module tb_mdu;

  localparam int MulLat = 5;
  localparam int DivLat = 10;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int passes = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu #(
    .MUL_LAT (MulLat),
    .DIV_LAT (DivLat)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Reference model: returns the {HI, LO} pair after the operation completes.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = {hi, lo};
    case (op)
      OpMult:  r = sa * sb;
      OpMultu: r = ua * ub;
      OpDiv: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      OpDivu: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[31:0], uq[31:0]};
      end
      OpMthi:  r = {a, lo};
      OpMtlo:  r = {hi, a};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op == OpMult || op == OpMultu) return MulLat;
    if (op == OpDiv || op == OpDivu) return DivLat;
    return 0;
  endfunction

  // Called at a negedge: issues one Start, counts busy cycles, returns at the first idle negedge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy, output bit held);
    logic [31:0] h0, l0;
    h0 = HI;
    l0 = LO;
    MDUOp = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'($urandom); A = $urandom; B = $urandom;
    nbusy = 0;
    held  = 1'b1;
    while (Busy && nbusy < 64) begin
      nbusy++;
      if (HI !== h0 || LO !== l0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDUOp = OpNop; A = '0; B = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else passes++;
    checks++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", HI); else passes++;
    checks++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", LO); else passes++;
  endtask

  task automatic test_mult();
    int nb; bit held;
    do_op(OpMult, 32'hFFFFFFFE, 32'd3, nb, held);
    checks++; if (nb !== 5) $display("FAIL mult_busy: got %0d want 5", nb); else passes++;
    checks++; if (!held) $display("FAIL mult_hold: HI/LO changed while busy"); else passes++;
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", HI);
    else passes++;
    checks++; if (LO !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want fffffffa", LO);
    else passes++;
    do_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, held);
    checks++; if (nb !== 5) $display("FAIL multu_busy: got %0d want 5", nb); else passes++;
    checks++; if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001)
      $display("FAIL multu_res: got %h_%h want fffffffe_00000001", HI, LO);
    else passes++;
    m_hi = HI; m_lo = LO;
  endtask

  task automatic test_div();
    int nb; bit held;
    do_op(OpDiv, 32'hFFFFFFF9, 32'd2, nb, held);
    checks++; if (nb !== 10) $display("FAIL div_busy: got %0d want 10", nb); else passes++;
    checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD)
      $display("FAIL div_res: got %h_%h want ffffffff_fffffffd", HI, LO);
    else passes++;
    do_op(OpMthi, 32'h1234, 32'd0, nb, held);
    checks++; if (nb !== 0 || HI !== 32'h1234)
      $display("FAIL mthi: got busy=%0d hi=%h want busy=0 hi=1234", nb, HI);
    else passes++;
    do_op(OpMtlo, 32'h5678, 32'd0, nb, held);
    checks++; if (nb !== 0 || LO !== 32'h5678)
      $display("FAIL mtlo: got busy=%0d lo=%h want busy=0 lo=5678", nb, LO);
    else passes++;
    do_op(OpDiv, 32'h77, 32'd0, nb, held);
    checks++; if (nb !== 10) $display("FAIL div0_busy: got %0d want 10", nb); else passes++;
    checks++; if (HI !== 32'h1234 || LO !== 32'h5678)
      $display("FAIL div0_res: got %h_%h want 00001234_00005678", HI, LO);
    else passes++;
    do_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, nb, held);
    checks++; if (HI !== 32'h0 || LO !== 32'h80000000)
      $display("FAIL div_ovf: got %h_%h want 00000000_80000000", HI, LO);
    else passes++;
    m_hi = HI; m_lo = LO;
  endtask

  task automatic test_nop();
    int nb; bit held;
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO;
    do_op(OpNop, 32'hCAFEF00D, 32'h1, nb, held);
    do_op(3'd7, 32'hBEEF0001, 32'h2, nb, held);
    checks++; if (nb !== 0 || HI !== h0 || LO !== l0)
      $display("FAIL nop: got busy=%0d %h_%h want busy=0 %h_%h", nb, HI, LO, h0, l0);
    else passes++;
  endtask

  task automatic test_random();
    int nb; bit held;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ((op == OpDiv || op == OpDivu) && $urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(1, 9));
      exp = model(op, a, b, m_hi, m_lo);
      do_op(op, a, b, nb, held);
      checks++; if (nb !== lat_of(op) || !held)
        $display("FAIL rand_busy[%0d]: op=%0d got busy=%0d held=%b want %0d held=1",
                 i, op, nb, held, lat_of(op));
      else passes++;
      checks++; if ({HI, LO} !== exp)
        $display("FAIL rand_res[%0d]: op=%0d a=%h b=%h got %h_%h want %h", i, op, a, b,
                 HI, LO, exp);
      else passes++;
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  task automatic test_start_while_busy();
    int nb;
    logic [63:0] exp;
    exp = model(OpMult, 32'h00012345, 32'hFFFF0003, m_hi, m_lo);
    MDUOp = OpMult; A = 32'h00012345; B = 32'hFFFF0003; Start = 1'b1;
    @(negedge clk);
    nb = 0;
    if (Busy) nb++;
    MDUOp = OpMthi; A = 32'hAAAA; B = 32'd0; Start = 1'b1;
    @(negedge clk);
    if (Busy) nb++;
    MDUOp = OpDiv; A = $urandom; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    while (Busy && nb < 64) begin
      nb++;
      @(negedge clk);
    end
    checks++; if (nb !== 5) $display("FAIL busy_ignore_len: got %0d want 5", nb); else passes++;
    checks++; if ({HI, LO} !== exp)
      $display("FAIL busy_ignore_res: got %h_%h want %h", HI, LO, exp);
    else passes++;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) $display("FAIL busy_ignore_queued: got %b want 0", Busy);
    else passes++;
    m_hi = exp[63:32]; m_lo = exp[31:0];
  endtask

  task automatic test_back_to_back();
    int nb1, nb2; bit held;
    logic [63:0] exp;
    exp = model(OpMultu, 32'h9, 32'h7, m_hi, m_lo);
    do_op(OpMultu, 32'h9, 32'h7, nb1, held);
    do_op(OpDivu, 32'h55, 32'd0, nb2, held);
    checks++; if (nb1 !== 5 || nb2 !== 10)
      $display("FAIL b2b_busy: got %0d,%0d want 5,10", nb1, nb2);
    else passes++;
    checks++; if ({HI, LO} !== exp)
      $display("FAIL b2b_res: got %h_%h want %h", HI, LO, exp);
    else passes++;
    do_op(OpMtlo, 32'h0BADCAFE, 32'd0, nb1, held);
    checks++; if (LO !== 32'h0BADCAFE || HI !== exp[63:32])
      $display("FAIL b2b_mtlo: got %h_%h want %h_0badcafe", HI, LO, exp[63:32]);
    else passes++;
    m_hi = HI; m_lo = LO;
  endtask

  task automatic test_reset_abort();
    int nb; bit held; bit stayed;
    do_op(OpMthi, 32'hDEADBEEF, 32'd0, nb, held);
    MDUOp = OpMult; A = 32'd5; B = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL abort: got busy=%b %h_%h want busy=0 0_0", Busy, HI, LO);
    else passes++;
    stayed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) stayed = 1'b0;
    end
    checks++; if (!stayed) $display("FAIL abort_late: got late commit %h_%h want 0_0", HI, LO);
    else passes++;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_nop();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
